// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared RV32I definitions for the issue-stage scoreboard.
//   XLEN / REG_W  : datapath and register-index widths
//   OPC_*         : base opcodes the scoreboard understands
//   opUseT        : which operand fields an opcode actually uses
//   decodeUse()   : maps an opcode to its operand usage
// ---------------------------------------------------------------------------
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic usesRs1;
        logic usesRs2;
        logic writesRd;
    } opUseT;

    // Unknown opcodes use nothing, so they never stall and never reserve a register.
    function automatic opUseT decodeUse(input logic [6:0] opc);
        opUseT u;
        u = '0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL:   u = '{usesRs1: 1'b0, usesRs2: 1'b0, writesRd: 1'b1};
            OPC_JALR, OPC_LOAD, OPC_OPIMM: u = '{usesRs1: 1'b1, usesRs2: 1'b0, writesRd: 1'b1};
            OPC_BRANCH, OPC_STORE:         u = '{usesRs1: 1'b1, usesRs2: 1'b1, writesRd: 1'b0};
            OPC_OP:                        u = '{usesRs1: 1'b1, usesRs2: 1'b1, writesRd: 1'b1};
            default:                       u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/ins_field_dec.sv
// ---------------------------------------------------------------------------
// ins_field_dec
// Purely combinational field extractor for the issue stage.
//   i_ins       : RV32I instruction word
//   o_rs1/o_rs2 : source register indices (always extracted)
//   o_rd        : destination register index (always extracted)
//   o_usesRs1   : opcode reads rs1
//   o_usesRs2   : opcode reads rs2
//   o_hasRd     : opcode writes a real destination (rd == x0 does not count)
// ---------------------------------------------------------------------------
module ins_field_dec
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0]  i_ins,
    output logic [REG_W-1:0] o_rs1,
    output logic [REG_W-1:0] o_rs2,
    output logic [REG_W-1:0] o_rd,
    output logic             o_usesRs1,
    output logic             o_usesRs2,
    output logic             o_hasRd
);

    opUseT w_use;
    logic  w_unusedBits;

    assign o_rs1 = i_ins[19:15];
    assign o_rs2 = i_ins[24:20];
    assign o_rd  = i_ins[11:7];

    assign w_use = decodeUse(i_ins[6:0]);

    assign o_usesRs1 = w_use.usesRs1;
    assign o_usesRs2 = w_use.usesRs2;
    // Writes to x0 are discarded by the register file, so they never need a reservation.
    assign o_hasRd   = w_use.writesRd & (i_ins[11:7] != '0);

    // funct3/funct7 do not affect operand usage.
    assign w_unusedBits = ^{i_ins[31:25], i_ins[14:12]};

endmodule

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Issue-stage hazard controller: tracks one busy bit per architectural
// register and holds the incoming instruction until its sources and
// destination are free and the outstanding-write budget allows it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ins_valid/ins_dec_in: instruction offered by decode
//   ins_ready           : instruction may issue this cycle (combinational)
//   rs1/rs2/rd          : decoded register fields (combinational)
//   wb_valid/wb_rd      : writeback completing this cycle
//   flush               : synchronous clear of all pending writes
//   busy_mask/pend_cnt  : registered reservation state
//   stall_cnt           : saturating count of stalled valid cycles
//   wb_err              : sticky flag for writebacks with no reservation
// ---------------------------------------------------------------------------
module reg_scoreboard
    import rv32_pkg::*;
#(
    parameter int MAX_PENDING = 8,
    parameter bit WB_BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ins_valid,
    input  logic [XLEN-1:0]  ins_dec_in,
    output logic             ins_ready,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2,
    output logic [REG_W-1:0] rd,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             flush,
    output logic [XLEN-1:0]  busy_mask,
    output logic [4:0]       pend_cnt,
    output logic [15:0]      stall_cnt,
    output logic             wb_err
);

    logic [XLEN-1:0] r_busyMask;
    logic [4:0]      r_pendCnt;
    logic [15:0]     r_stallCnt;
    logic            r_wbErr;

    logic            w_usesRs1;
    logic            w_usesRs2;
    logic            w_hasRd;
    logic [XLEN-1:0] w_bypassMask;
    logic [XLEN-1:0] w_effBusy;
    logic            w_wbHit;
    logic            w_full;
    logic            w_hazard;
    logic            w_issue;
    logic [XLEN-1:0] w_busyNext;
    logic [4:0]      w_pendNext;

    ins_field_dec u_dec (
        .i_ins     (ins_dec_in),
        .o_rs1     (rs1),
        .o_rs2     (rs2),
        .o_rd      (rd),
        .o_usesRs1 (w_usesRs1),
        .o_usesRs2 (w_usesRs2),
        .o_hasRd   (w_hasRd)
    );

    // A writeback landing this cycle can hide its register from the hazard check.
    assign w_bypassMask = (WB_BYPASS && wb_valid) ? (32'h1 << wb_rd) : '0;
    assign w_effBusy    = r_busyMask & ~w_bypassMask;

    // Only a writeback that matches a reservation retires a pending write.
    assign w_wbHit = wb_valid & (wb_rd != '0) & r_busyMask[wb_rd];
    assign w_full  = (r_pendCnt == 5'(MAX_PENDING));

    // RAW on either source, WAW on the destination, or no room for another reservation.
    assign w_hazard = (w_usesRs1 & w_effBusy[rs1])
                    | (w_usesRs2 & w_effBusy[rs2])
                    | (w_hasRd   & w_effBusy[rd])
                    | (w_hasRd   & w_full & ~w_wbHit);

    assign ins_ready = ~w_hazard & ~flush;
    assign w_issue   = ins_valid & ins_ready & w_hasRd;

    // Clear for the writeback first so an issue to the same register re-reserves it.
    always_comb begin
        w_busyNext = r_busyMask;
        if (w_wbHit) begin
            w_busyNext[wb_rd] = 1'b0;
        end
        if (w_issue) begin
            w_busyNext[rd] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
        if (flush) begin
            w_busyNext = '0;
        end
    end

    // An issue and a retire in the same cycle cancel out in the count.
    always_comb begin
        w_pendNext = r_pendCnt;
        case ({w_issue, w_wbHit})
            2'b10:   w_pendNext = r_pendCnt + 5'd1;
            2'b01:   w_pendNext = r_pendCnt - 5'd1;
            default: w_pendNext = r_pendCnt;
        endcase
        if (flush) begin
            w_pendNext = '0;
        end
    end

    // Reservation state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busyMask <= '0;
            r_pendCnt  <= '0;
        end else begin
            r_busyMask <= w_busyNext;
            r_pendCnt  <= w_pendNext;
        end
    end

    // Stall statistics and writeback error flag survive a flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
            r_wbErr    <= 1'b0;
        end else begin
            if (ins_valid && !ins_ready && (r_stallCnt != 16'hFFFF)) begin
                r_stallCnt <= r_stallCnt + 16'd1;
            end
            if (wb_valid && !flush && !w_wbHit) begin
                r_wbErr <= 1'b1;
            end
        end
    end

    assign busy_mask = r_busyMask;
    assign pend_cnt  = r_pendCnt;
    assign stall_cnt = r_stallCnt;
    assign wb_err    = r_wbErr;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
// Directed and random traffic against reg_scoreboard with MAX_PENDING=4 and
// WB_BYPASS=1. A behavioural model predicts ins_ready each cycle and the
// registered state after each clock; registered expectations are queued when
// the stimulus is driven and popped once the clock edge has happened.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

    localparam int MAXP = 4;
    localparam bit BYP  = 1'b1;

    logic        clk;
    logic        rst_n;
    logic        ins_valid;
    logic [31:0] ins_dec_in;
    logic        ins_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic [4:0]  pend_cnt;
    logic [15:0] stall_cnt;
    logic        wb_err;

    typedef struct {
        logic [31:0] busy;
        int          pend;
        int          stall;
        logic        err;
    } expT;

    expT         expQ[$];
    int          nCompared   = 0;
    int          nMismatched = 0;

    logic [31:0] mBusy;
    int          mPend;
    int          mStall;
    logic        mErr;

    reg_scoreboard #(.MAX_PENDING(MAXP), .WB_BYPASS(BYP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ins_valid  (ins_valid),
        .ins_dec_in (ins_dec_in),
        .ins_ready  (ins_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush      (flush),
        .busy_mask  (busy_mask),
        .pend_cnt   (pend_cnt),
        .stall_cnt  (stall_cnt),
        .wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Operand usage {rs1, rs2, rd} straight from the opcode table.
    function automatic logic [2:0] useOf(input logic [31:0] ins);
        logic [2:0] u;
        case (ins[6:0])
            7'b0110111, 7'b0010111, 7'b1101111: u = 3'b001;
            7'b1100111, 7'b0000011, 7'b0010011: u = 3'b101;
            7'b1100011, 7'b0100011:             u = 3'b110;
            7'b0110011:                         u = 3'b111;
            default:                            u = 3'b000;
        endcase
        if (ins[11:7] == 5'd0) u[0] = 1'b0;
        return u;
    endfunction

    function automatic logic wbHitOf(input logic wbv, input logic [4:0] wbr);
        return wbv && (wbr != 5'd0) && mBusy[wbr];
    endfunction

    function automatic logic readyOf(input logic [31:0] ins, input logic wbv,
                                     input logic [4:0] wbr, input logic fl);
        logic [2:0]  u;
        logic [31:0] eff;
        logic        haz;
        u   = useOf(ins);
        eff = mBusy;
        if (BYP && wbv) eff[wbr] = 1'b0;
        haz = (u[2] && eff[ins[19:15]]) || (u[1] && eff[ins[24:20]]) ||
              (u[0] && eff[ins[11:7]]) ||
              (u[0] && (mPend == MAXP) && !wbHitOf(wbv, wbr));
        return !haz && !fl;
    endfunction

    task automatic checkOutput();
        expT e;
        nCompared++;
        assert (expQ.size() != 0) else begin
            nMismatched++;
            $error("[TB] FAIL queue: observed=empty expected=entry");
        end
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            check("busy_mask", busy_mask, e.busy);
            check("pend_cnt", 32'(pend_cnt), 32'(e.pend));
            check("stall_cnt", 32'(stall_cnt), 32'(e.stall));
            check("wb_err", 32'(wb_err), 32'(e.err));
        end
    endtask

    // One clock of stimulus: check combinational outputs, advance the model, then the registers.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic wbv,
                                 input logic [4:0] wbr, input logic fl);
        logic [2:0] u;
        logic       rdy;
        logic       hit;
        expT        e;
        ins_valid  = v;
        ins_dec_in = ins;
        wb_valid   = wbv;
        wb_rd      = wbr;
        flush      = fl;
        #1;
        u   = useOf(ins);
        rdy = readyOf(ins, wbv, wbr, fl);
        hit = wbHitOf(wbv, wbr);
        check("ins_ready", 32'(ins_ready), 32'(rdy));
        check("fields", 32'({rs1, rs2, rd}), 32'({ins[19:15], ins[24:20], ins[11:7]}));
        if (v && !rdy && mStall < 65535) mStall++;
        if (fl) begin
            mBusy = '0;
            mPend = 0;
        end else begin
            if (wbv && !hit) mErr = 1'b1;
            if (hit) begin
                mBusy[wbr] = 1'b0;
                mPend--;
            end
            if (v && rdy && u[0]) begin
                mBusy[ins[11:7]] = 1'b1;
                mPend++;
            end
        end
        e.busy  = mBusy;
        e.pend  = mPend;
        e.stall = mStall;
        e.err   = mErr;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic modelReset();
        mBusy  = '0;
        mPend  = 0;
        mStall = 0;
        mErr   = 1'b0;
        expQ.delete();
    endtask

    localparam logic [31:0] ADD_X3    = 32'h002081B3;
    localparam logic [31:0] SUB_X4_X3 = 32'h40118233;
    localparam logic [31:0] ADDI_X1   = 32'h00100093;
    localparam logic [31:0] ADDI_X2   = 32'h00100113;
    localparam logic [31:0] ADDI_X5   = 32'h00100293;
    localparam logic [31:0] ADDI_X6   = 32'h00100313;
    localparam logic [31:0] ADDI_X7   = 32'h00100393;
    localparam logic [31:0] SW_X1     = 32'h00102023;
    localparam logic [31:0] SW_X0     = 32'h00002023;

    initial begin
        logic [6:0]  opcs [10];
        logic [31:0] ins;
        logic        v;
        logic        wbv;
        logic [4:0]  wbr;
        logic        fl;

        opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                 7'b0010011, 7'b1100011, 7'b0100011, 7'b0110011, 7'b1110011};

        rst_n      = 1'b0;
        ins_valid  = 1'b0;
        ins_dec_in = '0;
        wb_valid   = 1'b0;
        wb_rd      = '0;
        flush      = 1'b0;
        modelReset();
        #1;
        check("reset busy", busy_mask, 32'h0);
        check("reset pend", 32'(pend_cnt), 32'h0);
        check("reset stall", 32'(stall_cnt), 32'h0);
        check("reset err", 32'(wb_err), 32'h0);
        #2;
        rst_n = 1'b1;

        $display("[TB] issue add x3,x1,x2");
        applyStimulus(1'b1, ADD_X3, 1'b0, 5'd0, 1'b0);
        check("add busy", busy_mask, 32'h8);
        check("add pend", 32'(pend_cnt), 32'd1);

        $display("[TB] RAW stall on x3, released by bypassed writeback");
        repeat (3) applyStimulus(1'b1, SUB_X4_X3, 1'b0, 5'd0, 1'b0);
        check("raw stall", 32'(stall_cnt), 32'd3);
        applyStimulus(1'b1, SUB_X4_X3, 1'b1, 5'd3, 1'b0);
        check("bypass busy", busy_mask, 32'h10);

        $display("[TB] same-cycle issue and writeback on x5");
        applyStimulus(1'b1, ADDI_X5, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, ADDI_X5, 1'b1, 5'd5, 1'b0);
        check("same busy", busy_mask, 32'h30);
        check("same pend", 32'(pend_cnt), 32'd2);

        $display("[TB] pending limit");
        applyStimulus(1'b1, ADDI_X1, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, ADDI_X2, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, ADDI_X6, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, SW_X1, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, SW_X0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, ADDI_X6, 1'b1, 5'd1, 1'b0);
        check("full busy", busy_mask, 32'h74);
        check("full pend", 32'(pend_cnt), 32'd4);

        $display("[TB] writeback error and flush");
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd7, 1'b0);
        check("wb_err set", 32'(wb_err), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd2, 1'b0);
        applyStimulus(1'b1, ADDI_X7, 1'b1, 5'd4, 1'b1);
        check("flush busy", busy_mask, 32'h0);
        check("flush pend", 32'(pend_cnt), 32'd0);
        check("flush err kept", 32'(wb_err), 32'd1);

        $display("[TB] asynchronous reset during a stall");
        applyStimulus(1'b1, ADD_X3, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, SUB_X4_X3, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, SUB_X4_X3, 1'b0, 5'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async busy", busy_mask, 32'h0);
        check("async pend", 32'(pend_cnt), 32'h0);
        check("async stall", 32'(stall_cnt), 32'h0);
        check("async err", 32'(wb_err), 32'h0);
        modelReset();
        #2;
        rst_n = 1'b1;

        $display("[TB] random traffic");
        for (int i = 0; i < 10000; i++) begin
            v   = ($urandom_range(0, 9) < 7);
            ins = {7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'd0,
                   5'($urandom_range(0, 7)), opcs[$urandom_range(0, 9)]};
            wbr = 5'($urandom_range(1, 7));
            wbv = mBusy[wbr] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 60) == 0);
            fl  = ($urandom_range(0, 199) == 0);
            applyStimulus(v, ins, wbv, wbr, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
